hex_scan_display: RTL and testbench
===================================

Name: hex_scan_display

Overview:
- Parametrised successor to the team's single-digit hex-to-seven-segment decoder.
- Drives NUM_DIGITS multiplexed 7-segment digits from one shared segment bus, scanning one digit per refresh slot.
- Adds per-digit decimal points, leading-zero suppression, an inter-digit blanking gap (anti-ghosting), a load strobe and a frame marker.
- Sits between core logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SLOT_CYC, 50000, clock cycles per digit slot (>= BLANK_CYC+2).
- BLANK_CYC, 500, cycles at the start of each slot with all digit enables inactive.
- ACTIVE_LOW, 1, 1 = seg, dp and digit_sel active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable. When low, the display is dark and the counters hold.
- load  in  1  single-cycle strobe that captures value, dp_in and lz_en.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i is shown on digit i (digit 0 is rightmost/LS).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments; bit0=a, bit1=b ... bit6=g.
- dp  out  1  decimal-point segment.
- digit_sel  out  NUM_DIGITS  one-hot digit enable (polarity per ACTIVE_LOW).
- frame  out  1  one-cycle pulse when digit index wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (async, active-high):
  - value_q=0, dp_q=0, lz_q=0, slot_cnt=0, idx=0.
  - All outputs inactive: seg all off, dp off, digit_sel none asserted, frame=0. With ACTIVE_LOW=1, seg=7'h7F, dp=1, digit_sel all 1s.
  - Reset mid-scan returns to digit 0, slot start; the captured value is lost.
- Load: when load=1 at a rising edge, value_q/dp_q/lz_q take the inputs. load is honoured regardless of en. The new data reaches the outputs one cycle later (registered outputs).
- Slot counter:
  - When en=1, slot_cnt increments each cycle.
  - At SLOT_CYC-1 it wraps to 0 and idx advances. idx wraps NUM_DIGITS-1 -> 0, and frame pulses for exactly one cycle on the wrap edge.
- Digit enable and blanking:
  - digit_sel asserts bit idx only while slot_cnt >= BLANK_CYC. During slot_cnt < BLANK_CYC, no digit is enabled.
  - All outputs are registered: 1-cycle latency from slot_cnt/idx/value_q to pins.
- Decode:
  - seg = SEG_LUT[value_q nibble idx]. Active-high LUT: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - Inverted when ACTIVE_LOW=1.
- Decimal point: dp = dp_q[idx] at the same polarity as seg.
- Leading-zero suppression (lz_q=1):
  - Digit i is suppressed if nibbles NUM_DIGITS-1 down to i are all zero and i != 0. Digit 0 is never suppressed, so value 0 shows a single "0".
  - A suppressed digit drives seg off but still shows dp if dp_q[i]=1.
- Enable off:
  - en=0 forces seg/dp/digit_sel inactive on the next edge and freezes slot_cnt and idx.
  - Re-enable resumes from the frozen count.
- Simultaneous load and slot wrap: both take effect on the same edge. The new digit shows new data.
- Width rule: slot_cnt width is clog2(SLOT_CYC); idx width is clog2(NUM_DIGITS) (min 1).

Decomposition:
- Package hex_disp_pkg holds:
  - SEG_LUT constant (16 x 7, active-high).
  - Segment bit index constants SEG_A..SEG_G.
  - A function hex_to_seg(nibble) used by the top and by the bench model.
- One sub-module: hex_seg_decode (combinational nibble -> 7-bit, polarity parameter). It is the decoder generalised with a polarity parameter.
- Scan and suppression logic stays in hex_scan_display.

Test Plan:
- Configuration for all scenarios: NUM_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2, ACTIVE_LOW=1.
- Reset: assert rst mid-slot -> seg=7'h7F, dp=1, digit_sel=4'hF, frame=0 asynchronously. After release with en=1, digit_sel=4'hE first appears at cycle 3.
- Scan order: load value=16'h1A3F, lz_en=0, en=1 -> per slot digit_sel E,D,B,7 with seg ~71,~4F,~77,~06 (F,3,A,1). frame pulses once every 32 cycles.
- Leading zeros: load 16'h0040, lz_en=1 -> digits 3 and 2 show seg=7F; digit 1 ~66; digit 0 ~3F. Load 16'h0000 -> only digit 0 shows ~3F.
- Decimal point: dp_in=4'b0100 with value 16'h0005, lz_en=1 -> digit 2 seg=7F and dp=0; other digits dp=1.
- Enable/blanking: drop en for 5 cycles mid-slot -> outputs inactive next cycle and slot_cnt held. Resume -> remaining slot length is preserved. No digit_sel assertion during the first 2 cycles of any slot.
- Load on wrap: pulse load with 16'hFFFF on the cycle idx wraps -> digit 0 of the new frame shows ~71 immediately.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multiplexed hex display.
// Segment tables are stored active-high; polarity is applied at the pins.
package hex_disp_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Element n is the pattern for nibble n (element 0 in the LSBs)
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to seven-segment decoder.
// ACTIVE_LOW selects the polarity of the returned pattern.
module hex_seg_decode
    import hex_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] raw;

    always_comb begin
        raw = hex_to_seg(nibble);
        seg = ACTIVE_LOW ? ~raw : raw;
    end

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver: scans NUM_DIGITS digits over one shared
// segment bus with blanking gap, decimal points and leading-zero suppression.
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame
);

    localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             slot_cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   value_q;
    logic [NUM_DIGITS-1:0]     dp_q;
    logic                      lz_q;

    logic                      slot_end;
    logic                      idx_end;
    logic                      blank;
    logic [3:0]                nib;
    logic                      cur_dp;
    logic                      cur_sup;
    logic                      zero_run;
    logic [NUM_DIGITS-1:0]     sup;
    logic [NUM_DIGITS-1:0]     onehot;
    logic [6:0]                dec_seg;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign idx_end  = (idx == DIGIT_LAST);
    assign blank    = (slot_cnt < BLANK_END);

    // A digit is suppressed when it and every digit above it are zero
    always_comb begin
        zero_run = 1'b1;
        sup      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (value_q[4*i +: 4] == 4'h0);
            sup[i]   = lz_q && zero_run && (i != 0);
        end
    end

    always_comb begin
        nib     = 4'h0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        onehot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = value_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_sup   = sup[i];
                onehot[i] = 1'b1;
            end
        end
    end

    hex_seg_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .nibble (nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q  <= '0;
            dp_q     <= '0;
            lz_q     <= 1'b0;
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            if (load) begin
                value_q <= value;
                dp_q    <= dp_in;
                lz_q    <= lz_en;
            end
            if (en) begin
                if (slot_end) begin
                    slot_cnt <= '0;
                    idx      <= idx_end ? '0 : idx + 1'b1;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            digit_sel <= SEL_OFF;
            frame     <= 1'b0;
        end else if (!en) begin
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            digit_sel <= SEL_OFF;
            frame     <= 1'b0;
        end else begin
            seg       <= cur_sup ? SEG_OFF : dec_seg;
            dp        <= ACTIVE_LOW ? ~cur_dp : cur_dp;
            digit_sel <= blank ? SEL_OFF
                               : (ACTIVE_LOW ? ~onehot : onehot);
            frame     <= slot_end && idx_end;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a cycle model feeding a
// scoreboard queue of expected pin values.
module tb_hex_scan_display;
    import hex_disp_pkg::*;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          lz_en = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    digit_sel;
    logic          frame;

    hex_scan_display #(
        .NUM_DIGITS (ND),
        .SLOT_CYC   (SLOT),
        .BLANK_CYC  (BLANK),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       frame;
    } exp_t;

    exp_t q[$];

    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;
    int          m_slot;
    int          m_idx;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = '0;
        m_dp   = '0;
        m_lz   = 1'b0;
        m_slot = 0;
        m_idx  = 0;
    endtask

    task automatic model_step();
        exp_t e;
        logic [3:0] n;
        logic s;
        if (rst) begin
            model_reset();
            return;
        end
        if (!en) begin
            e = '{seg: 7'h7F, dp: 1'b1, sel: 4'hF, frame: 1'b0};
        end else begin
            n = m_val[m_idx*4 +: 4];
            s = m_lz && (m_idx != 0) && ((m_val >> (m_idx*4)) == 16'h0);
            e.seg   = s ? 7'h7F : (7'h7F ^ lut[n]);
            e.dp    = ~m_dp[m_idx];
            e.sel   = (m_slot < BLANK) ? 4'hF : ~(4'b0001 << m_idx);
            e.frame = (m_slot == SLOT - 1) && (m_idx == ND - 1);
        end
        q.push_back(e);
        if (load) begin
            m_val = value;
            m_dp  = dp_in;
            m_lz  = lz_en;
        end
        if (en) begin
            if (m_slot == SLOT - 1) begin
                m_slot = 0;
                m_idx  = (m_idx + 1) % ND;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("seg", 16'(seg), 16'(e.seg));
        chk("dp", 16'(dp), 16'(e.dp));
        chk("digit_sel", 16'(digit_sel), 16'(e.sel));
        chk("frame", 16'(frame), 16'(e.frame));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out();
    endtask

    task automatic wait_sel(input logic [3:0] t);
        int n = 0;
        while (digit_sel !== t && n < 64) begin
            tick();
            n++;
        end
        chk("wait_sel", 16'(digit_sel), 16'(t));
    endtask

    initial begin
        int n;
        model_reset();

        for (int i = 0; i < 16; i++)
            chk("hex_to_seg", 16'(hex_to_seg(4'(i))), 16'(lut[i]));

        // Reset, then first enabled digit appears at cycle 3
        tick();
        tick();
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_sel", 16'(digit_sel), 16'hF);
        rst   = 1'b0;
        en    = 1'b1;
        load  = 1'b1;
        value = 16'h1A3F;
        tick();
        load = 1'b0;
        chk("cyc1_sel", 16'(digit_sel), 16'hF);
        tick();
        chk("cyc2_sel", 16'(digit_sel), 16'hF);
        tick();
        chk("cyc3_sel", 16'(digit_sel), 16'hE);
        chk("d0_seg", 16'(seg), 16'h0E);

        // Scan order
        wait_sel(4'hD);
        chk("d1_seg", 16'(seg), 16'h30);
        wait_sel(4'hB);
        chk("d2_seg", 16'(seg), 16'h08);
        wait_sel(4'h7);
        chk("d3_seg", 16'(seg), 16'h79);

        // Frame spacing
        n = 0;
        while (frame !== 1'b1 && n < 64) begin tick(); n++; end
        chk("frame_seen", 16'(frame), 16'h1);
        n = 0;
        do begin tick(); n++; end while (frame !== 1'b1 && n < 64);
        chk("frame_period", 16'(n), 16'd32);

        // Reset mid-slot
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("arst_seg", 16'(seg), 16'h7F);
        chk("arst_dp", 16'(dp), 16'h1);
        chk("arst_sel", 16'(digit_sel), 16'hF);
        chk("arst_frame", 16'(frame), 16'h0);
        q.delete();
        tick();
        rst = 1'b0;
        wait_sel(4'hE);
        chk("lost_val", 16'(seg), 16'h40);

        // Leading-zero suppression
        load  = 1'b1;
        value = 16'h0040;
        lz_en = 1'b1;
        tick();
        load = 1'b0;
        wait_sel(4'h7);
        chk("lz_d3", 16'(seg), 16'h7F);
        wait_sel(4'hE);
        chk("lz_d0", 16'(seg), 16'h40);
        wait_sel(4'hD);
        chk("lz_d1", 16'(seg), 16'h19);
        wait_sel(4'hB);
        chk("lz_d2", 16'(seg), 16'h7F);
        load  = 1'b1;
        value = 16'h0000;
        tick();
        load = 1'b0;
        wait_sel(4'hE);
        chk("z_d0", 16'(seg), 16'h40);
        wait_sel(4'hD);
        chk("z_d1", 16'(seg), 16'h7F);

        // Decimal point on a suppressed digit
        load  = 1'b1;
        value = 16'h0005;
        dp_in = 4'b0100;
        tick();
        load = 1'b0;
        wait_sel(4'hB);
        chk("dp_d2_seg", 16'(seg), 16'h7F);
        chk("dp_d2_dp", 16'(dp), 16'h0);
        wait_sel(4'hE);
        chk("dp_d0_seg", 16'(seg), 16'h12);
        chk("dp_d0_dp", 16'(dp), 16'h1);

        // Enable drop mid-slot
        n = 0;
        while (m_slot != 4 && n < 64) begin tick(); n++; end
        chk("mid_slot", 16'(m_slot), 16'd4);
        en = 1'b0;
        tick();
        chk("en_off_sel", 16'(digit_sel), 16'hF);
        chk("en_off_dp", 16'(dp), 16'h1);
        for (int i = 0; i < 4; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Load on the wrap edge
        dp_in = 4'b0000;
        lz_en = 1'b0;
        n = 0;
        while (!(m_slot == SLOT - 1 && m_idx == ND - 1) && n < 64) begin
            tick();
            n++;
        end
        chk("pre_wrap", 16'(m_slot), 16'(SLOT - 1));
        load  = 1'b1;
        value = 16'hFFFF;
        tick();
        load = 1'b0;
        chk("wrap_frame", 16'(frame), 16'h1);
        wait_sel(4'hE);
        chk("wrap_d0", 16'(seg), 16'h0E);
        for (int i = 0; i < 40; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
